pipe_exec_controller: RTL and testbench
=======================================

Name: pipe_exec_controller

Overview:
- Debug-side sequencer for the 5-stage MIPS pipeline. Decodes UART command bytes and drives `en_pipeline` for continuous-run or single-step execution.
- Detects program halt, then streams a state dump (PC, cycle count, register file, data memory) out through the UART TX handshake.
- Sits between uart rx/tx and the pipeline enable and debug read ports.

Parameters:
- NB_DATA, 32, datapath word width
- N_BITS, 8, UART byte width
- NB_REG, 5, register-file address width
- N_REGISTER, 32, registers dumped
- NB_MEM_ADDR, 7, data-memory word address width
- N_MEM_WORDS, 32, data-memory words dumped, starting at address 0
- NB_PC, 7, PC width
- WATCHDOG_CYCLES, 1000, run-cycle limit; used only with the optional feature

Ports:
- clock_i  in  1  system clock
- reset_i  in  1  synchronous, active-high reset
- rx_data_i  in  N_BITS  received command byte
- rx_done_i  in  1  one-cycle pulse; rx_data_i is valid
- halt_i  in  1  HALT instruction has reached WB
- pc_i  in  NB_PC  current fetch PC
- reg_data_i  in  NB_DATA  register-file debug read data
- mem_data_i  in  NB_DATA  data-memory debug read data
- tx_done_i  in  1  one-cycle pulse; TX finished a byte
- en_pipeline_o  out  1  pipeline enable
- reg_addr_o  out  NB_REG  register-file debug read address
- mem_addr_o  out  NB_MEM_ADDR  data-memory debug read address
- tx_start_o  out  1  one-cycle pulse; start sending tx_data_o
- tx_data_o  out  N_BITS  byte to transmit
- finished_o  out  1  program halted and final dump sent
- timeout_o  out  1  watchdog fired

Behaviour:
- Reset (synchronous, active-high):
  - Outputs: en_pipeline_o, tx_start_o, finished_o and timeout_o are 0; tx_data_o, reg_addr_o and mem_addr_o are 0.
  - Internal: state = IDLE, cycle counter = 0, word index = 0, byte index = 0.
  - Reset mid-run or mid-dump aborts immediately; no partial byte is completed.
- Commands are sampled only in IDLE when rx_done_i=1:
  - 0x63 'c' → RUN.
  - 0x73 's' → STEP.
  - Any other byte is ignored.
  - rx_done_i in any state other than IDLE is ignored.
- RUN:
  - en_pipeline_o=1 (registered).
  - Each cycle with en_pipeline_o=1 increments the cycle counter, saturating at all-ones.
  - On halt_i=1, en_pipeline_o drops the next cycle; go to DUMP with halted flag set.
- STEP:
  - en_pipeline_o=1 for exactly one cycle; counter +1.
  - Then DUMP; halted flag = halt_i sampled in that cycle.
- Dump order: word index w runs 0 … 1+N_REGISTER+N_MEM_WORDS.
  - w=0: PC, zero-extended.
  - w=1: cycle counter.
  - w=2..N_REGISTER+1: register w-2.
  - Remaining words: data memory word w-2-N_REGISTER.
- Dump states:
  - DUMP_ADDR: drive reg_addr_o / mem_addr_o.
  - DUMP_LATCH: capture data one cycle later, so both memories may be synchronous-read.
  - DUMP_SEND: pulse tx_start_o for one cycle with the current byte (MSB first, 4 bytes per word).
  - DUMP_WAIT: hold until tx_done_i, then next byte or next word.
  - en_pipeline_o=0 throughout DUMP.
- End of dump:
  - Halted flag set → FINISHED: finished_o=1; all commands ignored until reset.
  - Otherwise → IDLE, ready for the next command.
- tx_done_i outside DUMP_WAIT is ignored.
- tx_data_o is stable from the tx_start_o pulse until tx_done_i.
- halt_i while already in DUMP or IDLE has no effect.
- 's' issued after FINISHED does nothing (FINISHED is sticky).

Optional Feature:
- Macro PIPE_EXEC_WATCHDOG_EN.
  - Defined: in RUN, when the cycle counter reaches WATCHDOG_CYCLES without halt_i, the controller stops the pipeline, sets timeout_o=1 (sticky until reset) and dumps with the halted flag set, ending in FINISHED.
  - Undefined: timeout_o is tied to 0 and RUN continues indefinitely.

Decomposition:
- Shared package pipe_dbg_pkg:
  - State enum (IDLE, RUN, STEP, DUMP_ADDR, DUMP_LATCH, DUMP_SEND, DUMP_WAIT, FINISHED).
  - Command constants CMD_RUN=8'h63, CMD_STEP=8'h73.
  - Dump word-count constant.
- One natural sub-module, dump_serializer: word latch, byte-index counter, tx_start/tx_done handshake.
- The FSM and cycle counter stay in the top.

Test Plan:
- Reset, then rx 0x63; program halts after 10 enabled cycles → en_pipeline_o high 10 cycles; dump word1 = 0x0000000A; finished_o=1 after 4×(2+32+32)=264 tx_start_o pulses.
- Two 0x73 commands, no halt → exactly one en_pipeline_o cycle each; second dump word1 = 0x00000002; return to IDLE with finished_o=0.
- Register 3 = 0xDEADBEEF → bytes DE, AD, BE, EF at dump byte offsets 20–23; each tx_start_o is issued only after the preceding tx_done_i.
- Send 0x41 in IDLE, and 0x73 during DUMP → no state change; en_pipeline_o stays 0.
- Assert reset_i during DUMP_WAIT → next cycle all outputs 0; a subsequent 0x63 restarts with cycle counter = 0.
- With PIPE_EXEC_WATCHDOG_EN and WATCHDOG_CYCLES=50, halt_i never asserted → pipeline stops after 50 cycles; timeout_o=1; dump word1 = 0x00000032; finished_o=1.

Source files
------------

// File: rtl/pipe_dbg_pkg.sv
// Shared types and constants for the pipeline debug sequencer: FSM states,
// UART command bytes and dump-layout helpers.
package pipe_dbg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    STEP,
    DUMP_ADDR,
    DUMP_LATCH,
    DUMP_SEND,
    DUMP_WAIT,
    FINISHED
  } state_e;

  localparam logic [7:0] CMD_RUN  = 8'h63;
  localparam logic [7:0] CMD_STEP = 8'h73;

  // PC and cycle counter precede the register file and data memory.
  localparam int DUMP_HDR_WORDS = 2;
  localparam int DUMP_WORDS     = DUMP_HDR_WORDS + 32 + 32;

  function automatic int dump_words(input int n_reg, input int n_mem);
    return DUMP_HDR_WORDS + n_reg + n_mem;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dump_serializer.sv
// Splits a latched dump word into bytes (MSB first) and runs the
// tx_start/tx_done handshake one byte at a time.
module dump_serializer
  import pipe_dbg_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int N_BITS  = 8
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              latch_i,
  input  logic [NB_DATA-1:0] word_i,
  input  logic              send_i,
  input  logic              ack_i,
  output logic              tx_start_o,
  output logic [N_BITS-1:0] tx_data_o,
  output logic              last_byte_o
);

  localparam int BYTES   = NB_DATA / N_BITS;
  localparam int NB_BIDX = max_int($clog2(BYTES), 1);
  localparam logic [NB_BIDX-1:0] LAST_BYTE = NB_BIDX'(BYTES - 1);

  logic [NB_DATA-1:0] word_q;
  logic [NB_BIDX-1:0] byte_q;
  logic               tx_start_q;
  logic [N_BITS-1:0]  lane [BYTES];

  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_lane
      assign lane[gi] = word_q[NB_DATA-1-gi*N_BITS -: N_BITS];
    end
  endgenerate

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      word_q     <= '0;
      byte_q     <= '0;
      tx_start_q <= 1'b0;
    end else begin
      tx_start_q <= send_i;
      if (latch_i) begin
        word_q <= word_i;
        byte_q <= '0;
      end else if (ack_i) begin
        byte_q <= (byte_q == LAST_BYTE) ? '0 : byte_q + NB_BIDX'(1);
      end
    end
  end

  // Byte index only moves on tx_done, so the byte stays put while TX is busy.
  assign tx_data_o   = lane[byte_q];
  assign tx_start_o  = tx_start_q;
  assign last_byte_o = (byte_q == LAST_BYTE);

endmodule

// File: rtl/pipe_exec_controller.sv
// Debug sequencer: UART commands run or single-step the pipeline, then the
// PC, cycle count, registers and data memory are dumped over UART TX.
// Optional run watchdog is enabled by defining PIPE_EXEC_WATCHDOG_EN.
module pipe_exec_controller
  import pipe_dbg_pkg::*;
#(
  parameter int NB_DATA         = 32,
  parameter int N_BITS          = 8,
  parameter int NB_REG          = 5,
  parameter int N_REGISTER      = 32,
  parameter int NB_MEM_ADDR     = 7,
  parameter int N_MEM_WORDS     = 32,
  parameter int NB_PC           = 7,
  parameter int WATCHDOG_CYCLES = 1000
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic [N_BITS-1:0]      rx_data_i,
  input  logic                   rx_done_i,
  input  logic                   halt_i,
  input  logic [NB_PC-1:0]       pc_i,
  input  logic [NB_DATA-1:0]     reg_data_i,
  input  logic [NB_DATA-1:0]     mem_data_i,
  input  logic                   tx_done_i,
  output logic                   en_pipeline_o,
  output logic [NB_REG-1:0]      reg_addr_o,
  output logic [NB_MEM_ADDR-1:0] mem_addr_o,
  output logic                   tx_start_o,
  output logic [N_BITS-1:0]      tx_data_o,
  output logic                   finished_o,
  output logic                   timeout_o
);

  localparam int N_WORDS = dump_words(N_REGISTER, N_MEM_WORDS);
  localparam int NB_WIDX = max_int(max_int($clog2(N_WORDS), NB_REG), NB_MEM_ADDR);
  localparam logic [NB_WIDX-1:0] LAST_WORD = NB_WIDX'(N_WORDS - 1);
  localparam logic [NB_WIDX-1:0] REG_BASE  = NB_WIDX'(DUMP_HDR_WORDS);
  localparam logic [NB_WIDX-1:0] MEM_BASE  = NB_WIDX'(DUMP_HDR_WORDS + N_REGISTER);

  state_e                 state_q, state_d;
  logic [NB_WIDX-1:0]     widx_q, widx_d;
  logic                   halted_q, halted_d;
  logic                   en_q;
  logic [NB_DATA-1:0]     cycles_q;
  logic [NB_REG-1:0]      reg_addr_q;
  logic [NB_MEM_ADDR-1:0] mem_addr_q;
  logic [NB_DATA-1:0]     dump_word;
  logic                   last_byte;

`ifdef PIPE_EXEC_WATCHDOG_EN
  localparam logic [NB_DATA-1:0] WD_LAST = NB_DATA'(WATCHDOG_CYCLES - 1);
  logic timeout_q, timeout_d;
`endif

  always_comb begin
    state_d  = state_q;
    widx_d   = widx_q;
    halted_d = halted_q;
`ifdef PIPE_EXEC_WATCHDOG_EN
    timeout_d = timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (rx_done_i && rx_data_i == CMD_RUN)       state_d = RUN;
        else if (rx_done_i && rx_data_i == CMD_STEP) state_d = STEP;
      end
      RUN: begin
        if (halt_i) begin
          state_d  = DUMP_ADDR;
          halted_d = 1'b1;
          widx_d   = '0;
        end
`ifdef PIPE_EXEC_WATCHDOG_EN
        // This is the WATCHDOG_CYCLES-th enabled cycle; stop after it.
        else if (cycles_q >= WD_LAST) begin
          state_d   = DUMP_ADDR;
          halted_d  = 1'b1;
          timeout_d = 1'b1;
          widx_d    = '0;
        end
`endif
      end
      STEP: begin
        state_d  = DUMP_ADDR;
        halted_d = halt_i;
        widx_d   = '0;
      end
      DUMP_ADDR:  state_d = DUMP_LATCH;
      DUMP_LATCH: state_d = DUMP_SEND;
      DUMP_SEND:  state_d = DUMP_WAIT;
      DUMP_WAIT: begin
        if (tx_done_i) begin
          if (!last_byte) begin
            state_d = DUMP_SEND;
          end else if (widx_q == LAST_WORD) begin
            widx_d   = '0;
            halted_d = 1'b0;
            state_d  = halted_q ? FINISHED : IDLE;
          end else begin
            widx_d  = widx_q + NB_WIDX'(1);
            state_d = DUMP_ADDR;
          end
        end
      end
      FINISHED: state_d = FINISHED;
      default:  state_d = IDLE;
    endcase
  end

  // Addresses follow the next word index so they are stable throughout
  // DUMP_ADDR, giving synchronous-read memories a full cycle to respond.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      widx_q     <= '0;
      halted_q   <= 1'b0;
      en_q       <= 1'b0;
      cycles_q   <= '0;
      reg_addr_q <= '0;
      mem_addr_q <= '0;
    end else begin
      state_q  <= state_d;
      widx_q   <= widx_d;
      halted_q <= halted_d;
      en_q     <= (state_d == RUN) || (state_d == STEP);
      if (en_q && cycles_q != '1) cycles_q <= cycles_q + NB_DATA'(1);
      reg_addr_q <= (widx_d >= REG_BASE && widx_d < MEM_BASE) ? NB_REG'(widx_d - REG_BASE) : '0;
      mem_addr_q <= (widx_d >= MEM_BASE) ? NB_MEM_ADDR'(widx_d - MEM_BASE) : '0;
    end
  end

`ifdef PIPE_EXEC_WATCHDOG_EN
  always_ff @(posedge clock_i) begin
    if (reset_i) timeout_q <= 1'b0;
    else         timeout_q <= timeout_d;
  end
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    dump_word = mem_data_i;
    if (widx_q == '0)                dump_word = NB_DATA'(pc_i);
    else if (widx_q == NB_WIDX'(1))  dump_word = cycles_q;
    else if (widx_q < MEM_BASE)      dump_word = reg_data_i;
  end

  dump_serializer #(
    .NB_DATA (NB_DATA),
    .N_BITS  (N_BITS)
  ) u_ser (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .latch_i     (state_q == DUMP_LATCH),
    .word_i      (dump_word),
    .send_i      (state_d == DUMP_SEND),
    .ack_i       (tx_done_i && state_q == DUMP_WAIT),
    .tx_start_o  (tx_start_o),
    .tx_data_o   (tx_data_o),
    .last_byte_o (last_byte)
  );

  assign en_pipeline_o = en_q;
  assign reg_addr_o    = reg_addr_q;
  assign mem_addr_o    = mem_addr_q;
  assign finished_o    = (state_q == FINISHED);

endmodule

// File: tb/tb_pipe_exec_controller.sv
// Directed bench for pipe_exec_controller: run/step/dump, command filtering,
// reset mid-dump and (when PIPE_EXEC_WATCHDOG_EN is defined) the watchdog.
module tb_pipe_exec_controller;

  localparam int NBYTES = 264;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [7:0]  rx_data_i = '0;
  logic        rx_done_i = 1'b0;
  logic        halt_i = 1'b0;
  logic [6:0]  pc_i = 7'h55;
  logic [31:0] reg_data_i = '0;
  logic [31:0] mem_data_i = '0;
  logic        tx_done_i = 1'b0;
  logic        en_pipeline_o;
  logic [4:0]  reg_addr_o;
  logic [6:0]  mem_addr_o;
  logic        tx_start_o;
  logic [7:0]  tx_data_o;
  logic        finished_o;
  logic        timeout_o;

  logic [31:0] regfile [32];
  logic [31:0] dmem [128];
  logic [7:0]  dump_bytes [NBYTES];

  int tests = 0;
  int fails = 0;
  int en_cycles = 0;
  int tx_starts = 0;
  int nbytes;
  bit hs_ok;

  always #5 clk = ~clk;

  pipe_exec_controller #(.WATCHDOG_CYCLES(50)) dut (
    .clock_i       (clk),
    .reset_i       (reset_i),
    .rx_data_i     (rx_data_i),
    .rx_done_i     (rx_done_i),
    .halt_i        (halt_i),
    .pc_i          (pc_i),
    .reg_data_i    (reg_data_i),
    .mem_data_i    (mem_data_i),
    .tx_done_i     (tx_done_i),
    .en_pipeline_o (en_pipeline_o),
    .reg_addr_o    (reg_addr_o),
    .mem_addr_o    (mem_addr_o),
    .tx_start_o    (tx_start_o),
    .tx_data_o     (tx_data_o),
    .finished_o    (finished_o),
    .timeout_o     (timeout_o)
  );

  // Synchronous-read memories, one cycle of read latency.
  always @(posedge clk) begin
    reg_data_i <= regfile[reg_addr_o];
    mem_data_i <= dmem[mem_addr_o];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    if (en_pipeline_o === 1'b1) en_cycles++;
    if (tx_start_o === 1'b1) tx_starts++;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    rx_data_i = b;
    rx_done_i = 1'b1;
    tick();
    rx_done_i = 1'b0;
  endtask

  task automatic run_until_halt(input int n);
    en_cycles = 0;
    send_cmd(8'h63);
    for (int g = 0; g < 200 && en_cycles < n; g++) tick();
    halt_i = 1'b1;
    tick();
    halt_i = 1'b0;
  endtask

  // Acts as the UART TX: records each byte, answers tx_done two cycles later,
  // and optionally injects an 's' or stops early (left sitting in the wait).
  task automatic collect(input int abort_at, input int inject_at,
                         output int n, output bit ok);
    logic [7:0] b;
    bit fin;
    n = 0; ok = 1'b1; fin = 1'b0;
    for (int g = 0; g < 4000 && !fin; g++) begin
      if (tx_start_o === 1'b1) begin
        b = tx_data_o;
        dump_bytes[n] = b;
        n++;
        if (n - 1 == inject_at) begin
          rx_data_i = 8'h73;
          rx_done_i = 1'b1;
        end
        tick();
        rx_done_i = 1'b0;
        if (n - 1 == abort_at) begin
          fin = 1'b1;
        end else begin
          for (int k = 0; k < 2; k++) begin
            if (tx_start_o !== 1'b0 || tx_data_o !== b || en_pipeline_o !== 1'b0) ok = 1'b0;
            tick();
          end
          tx_done_i = 1'b1;
          tick();
          tx_done_i = 1'b0;
          if (n == NBYTES) fin = 1'b1;
        end
      end else begin
        tick();
      end
    end
  endtask

  function automatic logic [31:0] dword(input int w);
    return {dump_bytes[4*w], dump_bytes[4*w+1], dump_bytes[4*w+2], dump_bytes[4*w+3]};
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) regfile[i] = 32'h1000_0000 + i;
    regfile[3] = 32'hDEADBEEF;
    for (int i = 0; i < 128; i++) dmem[i] = 32'hA500_0000 + i;
    for (int i = 0; i < NBYTES; i++) dump_bytes[i] = '0;

    // Reset state
    repeat (3) tick();
    reset_i = 1'b0;
    tick();
    chk("rst_en", {31'b0, en_pipeline_o}, 32'd0);
    chk("rst_txs", {31'b0, tx_start_o}, 32'd0);
    chk("rst_txd", {24'b0, tx_data_o}, 32'd0);
    chk("rst_fin", {31'b0, finished_o}, 32'd0);
    chk("rst_to", {31'b0, timeout_o}, 32'd0);
    chk("rst_raddr", {27'b0, reg_addr_o}, 32'd0);
    chk("rst_maddr", {25'b0, mem_addr_o}, 32'd0);

    // Unknown command and halt while idle do nothing
    en_cycles = 0; tx_starts = 0;
    halt_i = 1'b1;
    send_cmd(8'h41);
    repeat (5) tick();
    halt_i = 1'b0;
    chk("idle_41_en", en_cycles, 0);
    chk("idle_41_tx", tx_starts, 0);

    // Run, halt after 10 enabled cycles, full dump
    run_until_halt(10);
    chk("run_en_cycles", en_cycles, 10);
    tx_starts = 0;
    collect(-1, -1, nbytes, hs_ok);
    chk("run_nbytes", nbytes, NBYTES);
    chk("run_tx_starts", tx_starts, NBYTES);
    chk("run_handshake", {31'b0, hs_ok}, 32'd1);
    chk("run_en_in_dump", en_cycles, 10);
    chk("run_w0_pc", dword(0), 32'h0000_0055);
    chk("run_w1_cycles", dword(1), 32'h0000_000A);
    chk("run_b20", {24'b0, dump_bytes[20]}, 32'hDE);
    chk("run_b23", {24'b0, dump_bytes[23]}, 32'hEF);
    chk("run_w5_reg3", dword(5), 32'hDEADBEEF);
    chk("run_w33_reg31", dword(33), 32'h1000_001F);
    chk("run_w41_mem7", dword(41), 32'hA500_0007);
    chk("run_w65_mem31", dword(65), 32'hA500_001F);
    chk("run_finished", {31'b0, finished_o}, 32'd1);

    // FINISHED is sticky: 's' ignored
    en_cycles = 0; tx_starts = 0;
    send_cmd(8'h73);
    repeat (8) tick();
    chk("fin_s_en", en_cycles, 0);
    chk("fin_s_tx", tx_starts, 0);
    chk("fin_sticky", {31'b0, finished_o}, 32'd1);

    // Two single steps without halt; an 's' injected mid-dump is ignored
    reset_i = 1'b1; tick(); reset_i = 1'b0;
    en_cycles = 0;
    send_cmd(8'h73);
    collect(-1, 100, nbytes, hs_ok);
    chk("step1_en", en_cycles, 1);
    chk("step1_nbytes", nbytes, NBYTES);
    chk("step1_w1", dword(1), 32'h0000_0001);
    chk("step1_fin", {31'b0, finished_o}, 32'd0);
    en_cycles = 0; tx_starts = 0;
    repeat (5) tick();
    chk("step1_idle_en", en_cycles, 0);
    chk("step1_idle_tx", tx_starts, 0);
    send_cmd(8'h73);
    collect(-1, -1, nbytes, hs_ok);
    chk("step2_en", en_cycles, 1);
    chk("step2_w1", dword(1), 32'h0000_0002);
    chk("step2_w5", dword(5), 32'hDEADBEEF);
    chk("step2_hs", {31'b0, hs_ok}, 32'd1);
    chk("step2_fin", {31'b0, finished_o}, 32'd0);

    reset_i = 1'b1; tick(); reset_i = 1'b0;
`ifdef PIPE_EXEC_WATCHDOG_EN
    // Watchdog: no halt, pipeline stops after 50 cycles
    en_cycles = 0;
    send_cmd(8'h63);
    for (int g = 0; g < 200 && en_pipeline_o === 1'b1; g++) tick();
    chk("wd_en_cycles", en_cycles, 50);
    chk("wd_timeout", {31'b0, timeout_o}, 32'd1);
    collect(-1, -1, nbytes, hs_ok);
    chk("wd_w1", dword(1), 32'h0000_0032);
    chk("wd_fin", {31'b0, finished_o}, 32'd1);
    chk("wd_timeout_sticky", {31'b0, timeout_o}, 32'd1);
`else
    // Without the watchdog a run keeps going
    en_cycles = 0;
    send_cmd(8'h63);
    repeat (60) tick();
    chk("nowd_en_cycles", en_cycles, 61);
    chk("nowd_en_high", {31'b0, en_pipeline_o}, 32'd1);
    chk("nowd_timeout", {31'b0, timeout_o}, 32'd0);
`endif

    // Reset while waiting for tx_done aborts the dump
    reset_i = 1'b1; tick(); reset_i = 1'b0;
    en_cycles = 0;
    send_cmd(8'h73);
    collect(3, -1, nbytes, hs_ok);
    chk("abort_txd_pre", {24'b0, tx_data_o}, 32'h55);
    reset_i = 1'b1;
    tick();
    chk("abort_en", {31'b0, en_pipeline_o}, 32'd0);
    chk("abort_txs", {31'b0, tx_start_o}, 32'd0);
    chk("abort_txd", {24'b0, tx_data_o}, 32'd0);
    chk("abort_fin", {31'b0, finished_o}, 32'd0);
    chk("abort_to", {31'b0, timeout_o}, 32'd0);
    reset_i = 1'b0;
    tx_starts = 0;
    repeat (4) tick();
    chk("abort_no_tx", tx_starts, 0);
    run_until_halt(3);
    chk("restart_en", en_cycles, 3);
    collect(-1, -1, nbytes, hs_ok);
    chk("restart_w1", dword(1), 32'h0000_0003);
    chk("restart_fin", {31'b0, finished_o}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
